// File: rtl/dmi_arbiter.sv
// Arbitrates the DM's single DMI register port between the JTAG DTM (port A)
// and a debug bus bridge (port B); one access outstanding, round-robin on ties.
module dmi_arbiter #(
    parameter int ABITS   = 7,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             a_wr_i,
    input  logic             a_rd_i,
    input  logic [ABITS-1:0] a_addr_i,
    input  logic [31:0]      a_wdata_i,
    output logic [31:0]      a_rdata_o,
    output logic             a_busy_o,
    output logic             a_err_o,
    input  logic             a_err_clr_i,
    input  logic             b_valid_i,
    output logic             b_ready_o,
    input  logic             b_we_i,
    input  logic [ABITS-1:0] b_addr_i,
    input  logic [31:0]      b_wdata_i,
    output logic             b_done_o,
    output logic [31:0]      b_rdata_o,
    output logic             b_err_o,
    output logic             dm_req_o,
    output logic             dm_we_o,
    output logic [ABITS-1:0] dm_addr_o,
    output logic [31:0]      dm_wdata_o,
    input  logic             dm_gnt_i,
    input  logic             dm_rvalid_i,
    input  logic [31:0]      dm_rdata_i
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RSP = 2'd2} state_t;
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

    state_t          state_q, state_d;
    port_t           owner_q, owner_d, last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic             a_full_q, a_full_d, a_we_q, a_we_d;
    logic [ABITS-1:0] a_addr_q, a_addr_d;
    logic [31:0]      a_wdata_q, a_wdata_d, a_rdata_q, a_rdata_d;
    logic             a_err_q, a_err_d;
    logic             b_full_q, b_full_d, b_we_q, b_we_d;
    logic [ABITS-1:0] b_addr_q, b_addr_d;
    logic [31:0]      b_wdata_q, b_wdata_d, b_rdata_q, b_rdata_d;
    logic             b_done_q, b_done_d, b_err_q, b_err_d;

    logic             own_we;
    logic [ABITS-1:0] own_addr;
    logic [31:0]      own_wdata;
    logic             cpl, cpl_err;
    logic [31:0]      cpl_data;
    logic             a_cpl, b_cpl, a_cmd, a_free, a_load, b_ready, b_load;

    assign own_we    = (owner_q == PORT_B) ? b_we_q    : a_we_q;
    assign own_addr  = (owner_q == PORT_B) ? b_addr_q  : a_addr_q;
    assign own_wdata = (owner_q == PORT_B) ? b_wdata_q : a_wdata_q;

    // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin : state_reg
        if (!rstn_i) begin
            state_q <= IDLE;
            owner_q <= PORT_A;
            last_q  <= PORT_B;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal gets a default first, so no path can infer a latch.
    always_comb begin : next_state
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        cpl      = 1'b0;
        cpl_err  = 1'b0;
        cpl_data = '0;
        unique case (state_q)
            IDLE: begin
                if (a_full_q || b_full_q) begin
                    if (a_full_q && b_full_q) owner_d = (last_q == PORT_A) ? PORT_B : PORT_A;
                    else                      owner_d = b_full_q ? PORT_B : PORT_A;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (dm_gnt_i) begin
                    if (own_we) begin
                        cpl     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (dm_rvalid_i) begin
                    cpl      = 1'b1;
                    cpl_data = dm_rdata_i;
                    state_d  = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cpl     = 1'b1;
                    cpl_err = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : outputs
        dm_req_o   = 1'b0;
        dm_we_o    = 1'b0;
        dm_addr_o  = '0;
        dm_wdata_o = '0;
        if (state_q == ISSUE) begin
            dm_req_o   = 1'b1;
            dm_we_o    = own_we;
            dm_addr_o  = own_addr;
            dm_wdata_o = own_wdata;
        end
    end

    // A slot freed by a completion can take a new command on the same edge.
    always_comb begin : slots
        a_cpl     = cpl && (owner_q == PORT_A);
        b_cpl     = cpl && (owner_q == PORT_B);
        a_cmd     = a_wr_i ^ a_rd_i;
        a_free    = !a_full_q || a_cpl;
        a_load    = a_cmd && a_free;
        a_full_d  = a_load ? 1'b1 : (a_cpl ? 1'b0 : a_full_q);
        a_we_d    = a_load ? a_wr_i    : a_we_q;
        a_addr_d  = a_load ? a_addr_i  : a_addr_q;
        a_wdata_d = a_load ? a_wdata_i : a_wdata_q;
        a_rdata_d = (a_cpl && !own_we) ? cpl_data : a_rdata_q;
        // Error set takes priority over a same-cycle clear.
        if ((a_cmd && !a_free) || (a_wr_i && a_rd_i) || (a_cpl && cpl_err)) a_err_d = 1'b1;
        else if (a_err_clr_i)                                                a_err_d = 1'b0;
        else                                                                 a_err_d = a_err_q;

        b_ready   = !b_full_q || b_cpl;
        b_load    = b_valid_i && b_ready;
        b_full_d  = b_load ? 1'b1 : (b_cpl ? 1'b0 : b_full_q);
        b_we_d    = b_load ? b_we_i    : b_we_q;
        b_addr_d  = b_load ? b_addr_i  : b_addr_q;
        b_wdata_d = b_load ? b_wdata_i : b_wdata_q;
        b_done_d  = b_cpl;
        b_rdata_d = b_cpl ? cpl_data : b_rdata_q;
        b_err_d   = b_cpl ? cpl_err  : b_err_q;
        last_d    = cpl ? owner_q : last_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin : slot_reg
        if (!rstn_i) begin
            a_full_q  <= 1'b0;
            a_we_q    <= 1'b0;
            a_addr_q  <= '0;
            a_wdata_q <= '0;
            a_rdata_q <= '0;
            a_err_q   <= 1'b0;
            b_full_q  <= 1'b0;
            b_we_q    <= 1'b0;
            b_addr_q  <= '0;
            b_wdata_q <= '0;
            b_done_q  <= 1'b0;
            b_rdata_q <= '0;
            b_err_q   <= 1'b0;
        end else begin
            a_full_q  <= a_full_d;
            a_we_q    <= a_we_d;
            a_addr_q  <= a_addr_d;
            a_wdata_q <= a_wdata_d;
            a_rdata_q <= a_rdata_d;
            a_err_q   <= a_err_d;
            b_full_q  <= b_full_d;
            b_we_q    <= b_we_d;
            b_addr_q  <= b_addr_d;
            b_wdata_q <= b_wdata_d;
            b_done_q  <= b_done_d;
            b_rdata_q <= b_rdata_d;
            b_err_q   <= b_err_d;
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign a_busy_o  = a_full_q;
    assign a_err_o   = a_err_q;
    assign b_ready_o = b_ready;
    assign b_done_o  = b_done_q;
    assign b_rdata_o = b_rdata_q;
    assign b_err_o   = b_err_q;
endmodule
